// File: rtl/keypoint_stream_detector.sv
// keypoint_stream_detector
// Streaming DoG extremum detector. Accepts one raster-order signed DoG sample
// per handshake and keeps the two previous rows in internal line buffers to
// form a 3x3 window. Each interior centre is tested against its 8 neighbours
// and a contrast threshold. Keypoints are queued in a first-word-fall-through
// FIFO, and entries that arrive while the FIFO is full are counted as dropped.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : frame start pulse, honoured only in IDLE
//   threshold  : unsigned contrast threshold, latched at start
//   mode       : bit0 enables maxima, bit1 enables minima, latched at start
//   dog_valid  : input sample valid
//   dog_data   : signed DoG sample
//   dog_ready  : sample accepted when dog_valid && dog_ready
//   kp_valid   : FIFO head valid
//   kp_ready   : consumer pops the FIFO head
//   kp_x/kp_y  : keypoint column/row
//   kp_pol     : 0 = maximum, 1 = minimum
//   busy       : frame in progress (RUN or DRAIN)
//   done       : one-cycle pulse at frame completion
//   drop_cnt   : keypoints lost to FIFO overflow this frame, saturating
module keypoint_stream_detector #(
   parameter int DOG_W      = 17,
   parameter int IMG_W      = 256,
   parameter int IMG_H      = 256,
   parameter int COORD_W    = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DOG_W-2:0]   threshold,
   input  logic [1:0]         mode,
   input  logic               dog_valid,
   input  logic [DOG_W-1:0]   dog_data,
   output logic               dog_ready,
   output logic               kp_valid,
   input  logic               kp_ready,
   output logic [COORD_W-1:0] kp_x,
   output logic [COORD_W-1:0] kp_y,
   output logic               kp_pol,
   output logic               busy,
   output logic               done,
   output logic [15:0]        drop_cnt
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2 * COORD_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t r_state;

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [DOG_W-2:0] r_thr;
   logic [1:0]       r_mode;

   // Line buffers: r_lb0 holds row y-1, r_lb1 holds row y-2
   logic [DOG_W-1:0] r_lb0 [IMG_W];
   logic [DOG_W-1:0] r_lb1 [IMG_W];

   // Window indexed [row][col]; row 0 = y-2, row 2 = current; col 2 newest
   logic signed [DOG_W-1:0] r_win [3][3];
   logic                    r_win_valid;
   logic [COORD_W-1:0]      r_win_x;
   logic [COORD_W-1:0]      r_win_y;

   logic               r_s1_valid;
   logic               r_s1_max;
   logic               r_s1_min;
   logic [COORD_W-1:0] r_s1_x;
   logic [COORD_W-1:0] r_s1_y;

   logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_cnt;

   logic w_accept;
   logic w_last;
   logic w_eval;
   logic [COL_W-1:0] w_cx;
   logic [ROW_W-1:0] w_cy;
   logic w_gt_all;
   logic w_lt_all;
   logic w_above;
   logic w_below;
   logic signed [DOG_W:0] w_cen_ext;
   logic signed [DOG_W:0] w_thr_ext;
   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_wr;
   logic w_drop;

   always_comb begin
      w_accept = dog_valid && dog_ready;
      w_last   = (r_col == COL_W'(IMG_W - 1)) && (r_row == ROW_W'(IMG_H - 1));
      // col>=2 guarantees the two older window columns came from this row
      w_eval   = (r_col >= COL_W'(2)) && (r_row >= ROW_W'(2));
      w_cx     = r_col - COL_W'(1);
      w_cy     = r_row - ROW_W'(1);
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         dog_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         drop_cnt  <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_thr     <= '0;
         r_mode    <= '0;
      end else begin
         done <= 1'b0;
         if (w_drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_RUN;
                  dog_ready <= 1'b1;
                  busy      <= 1'b1;
                  drop_cnt  <= '0;
                  r_col     <= '0;
                  r_row     <= '0;
                  r_thr     <= threshold;
                  r_mode    <= mode;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (r_col == COL_W'(IMG_W - 1)) begin
                     r_col <= '0;
                     r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
                  if (w_last) begin
                     r_state   <= S_DRAIN;
                     dog_ready <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (!r_win_valid && !r_s1_valid) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               dog_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Line buffers and window data carry no reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb0[r_col] <= dog_data;
         r_lb1[r_col] <= r_lb0[r_col];
         for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 2; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
         end
         r_win[0][2] <= r_lb1[r_col];
         r_win[1][2] <= r_lb0[r_col];
         r_win[2][2] <= dog_data;
      end
   end

   always_comb begin
      w_gt_all = 1'b1;
      w_lt_all = 1'b1;
      for (int unsigned r = 0; r < 3; r++) begin
         for (int unsigned c = 0; c < 3; c++) begin
            if (!(r == 1 && c == 1)) begin
               if (!(r_win[1][1] > r_win[r][c])) w_gt_all = 1'b0;
               if (!(r_win[1][1] < r_win[r][c])) w_lt_all = 1'b0;
            end
         end
      end
      w_cen_ext = {r_win[1][1][DOG_W-1], r_win[1][1]};
      w_thr_ext = {2'b00, r_thr};
      w_above   = w_cen_ext > w_thr_ext;
      w_below   = w_cen_ext < -w_thr_ext;
   end

   // Two-stage compare pipeline: window register, then compare register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_win_valid <= 1'b0;
         r_win_x     <= '0;
         r_win_y     <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_max    <= 1'b0;
         r_s1_min    <= 1'b0;
         r_s1_x      <= '0;
         r_s1_y      <= '0;
      end else begin
         r_win_valid <= w_accept && w_eval;
         if (w_accept) begin
            r_win_x <= COORD_W'(w_cx);
            r_win_y <= COORD_W'(w_cy);
         end
         r_s1_valid <= r_win_valid;
         r_s1_max   <= w_gt_all && w_above;
         r_s1_min   <= w_lt_all && w_below;
         r_s1_x     <= r_win_x;
         r_s1_y     <= r_win_y;
      end
   end

   always_comb begin
      w_push = r_s1_valid && ((r_s1_max && r_mode[0]) || (r_s1_min && r_mode[1]));
      w_pop  = kp_valid && kp_ready;
      w_full = (r_cnt == CNT_W'(FIFO_DEPTH));
      // A simultaneous pop frees the slot, so a push into a full FIFO still lands
      w_wr   = w_push && (!w_full || w_pop);
      w_drop = w_push && w_full && !w_pop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_mem[r_wr] <= {r_s1_x, r_s1_y, r_s1_min};
            r_wr        <= r_wr + PTR_W'(1);
         end
         if (w_pop)
            r_rd <= r_rd + PTR_W'(1);
         case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_comb begin
      kp_valid              = (r_cnt != '0);
      {kp_x, kp_y, kp_pol}  = r_mem[r_rd];
   end

endmodule

// File: tb/tb_keypoint_stream_detector.sv
module tb_keypoint_stream_detector;

   localparam int DW = 17;
   localparam int W  = 16;
   localparam int H  = 16;
   localparam int CW = 8;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-2:0] threshold;
   logic [1:0]    mode;
   logic          dog_valid;
   logic [DW-1:0] dog_data;
   logic          dog_ready;
   logic          kp_valid;
   logic          kp_ready;
   logic [CW-1:0] kp_x;
   logic [CW-1:0] kp_y;
   logic          kp_pol;
   logic          busy;
   logic          done;
   logic [15:0]   drop_cnt;

   keypoint_stream_detector #(
      .DOG_W(DW), .IMG_W(W), .IMG_H(H), .COORD_W(CW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .threshold(threshold), .mode(mode),
      .dog_valid(dog_valid), .dog_data(dog_data), .dog_ready(dog_ready),
      .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
      .kp_pol(kp_pol), .busy(busy), .done(done), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;
   int img [H][W];
   int acc_cyc [W*H];
   logic [2*CW:0] exp_q [$];
   int   n_done  = 0;
   int   kv_rise = 0;
   logic kv_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   // Scoreboard: compare every popped FIFO head against the expected queue
   always @(negedge clk) begin : mon
      logic [2*CW:0] e;
      if (done === 1'b1) n_done++;
      if (kp_valid === 1'b1 && kv_prev !== 1'b1) kv_rise = cyc;
      kv_prev = kp_valid;
      if (kp_valid === 1'b1 && kp_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("kp_unexpected", 32'(kp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("kp_head", 32'({kp_x, kp_y, kp_pol}), 32'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_img();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = 0;
   endtask

   // Reference extremum test on the whole image; pushes up to cap keypoints
   task automatic model(input int thr, input logic [1:0] md, input int cap, output int drops);
      int n;
      int c;
      bit mx;
      bit mn;
      n = 0;
      drops = 0;
      for (int y = 1; y < H - 1; y++) begin
         for (int x = 1; x < W - 1; x++) begin
            c  = img[y][x];
            mx = (c > thr);
            mn = (c < -thr);
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if (!(dy == 0 && dx == 0)) begin
                     if (!(c > img[y+dy][x+dx])) mx = 0;
                     if (!(c < img[y+dy][x+dx])) mn = 0;
                  end
            if ((mx && md[0]) || (mn && md[1])) begin
               if (n < cap) exp_q.push_back({CW'(x), CW'(y), mn});
               else drops++;
               n++;
            end
         end
      end
   endtask

   task automatic send(input int n, input int start_at);
      for (int i = 0; i < n; i++) begin
         dog_valid  = 1'b1;
         dog_data   = DW'(img[i / W][i % W]);
         start      = (i == start_at);
         acc_cyc[i] = cyc + 1;
         tick();
      end
      start     = 1'b0;
      dog_valid = 1'b0;
      dog_data  = '0;
   endtask

   task automatic run_frame(input int thr, input logic [1:0] md, input int cap, input int start_mid);
      int drops;
      int nd0;
      int lat;
      model(thr, md, cap, drops);
      nd0 = n_done;
      threshold = thr[DW-2:0];
      mode      = md;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      threshold = '0;
      mode      = 2'b11;
      check("start_busy", 32'(busy), 32'd1);
      check("start_ready", 32'(dog_ready), 32'd1);
      check("start_drop", 32'(drop_cnt), 32'd0);
      send(W * H, start_mid);
      for (int g = 0; g < 20 && done !== 1'b1; g++) tick();
      check("done_seen", 32'(done), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      lat = cyc - acc_cyc[W*H-1];
      check("done_latency", 32'(lat >= 3 && lat <= 4), 32'd1);
      check("drop_cnt", 32'(drop_cnt), 32'(drops));
      tick();
      check("done_pulse", 32'(done), 32'd0);
      repeat (8) tick();
      check("done_count", 32'(n_done - nd0), 32'd1);
      if (kp_ready) check("kp_missing", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      threshold = '0;
      mode      = '0;
      dog_valid = 1'b0;
      dog_data  = '0;
      kp_ready  = 1'b1;
      repeat (3) tick();
      check("reset_ctrl", 32'({dog_ready, kp_valid, kp_pol, busy, done}), 32'd0);
      check("reset_coord", 32'({kp_x, kp_y}), 32'd0);
      check("reset_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b1;
      tick();

      // 1: all-zero frame
      clear_img();
      run_frame(0, 2'b11, 1000, -1);

      // 2: single positive peak, then threshold and mode rejection
      clear_img();
      img[7][5] = 100;
      run_frame(10, 2'b01, 1000, -1);
      check("kp_latency", 32'(kv_rise - acc_cyc[8*W+6]), 32'd2);
      run_frame(100, 2'b01, 1000, -1);
      run_frame(10, 2'b10, 1000, -1);

      // 3: negative peak inside, then on borders
      clear_img();
      img[14][14] = -50;
      run_frame(10, 2'b11, 1000, -1);
      clear_img();
      img[3][15] = -50;
      img[9][0]  = -50;
      img[0][4]  = -50;
      run_frame(10, 2'b11, 1000, -1);

      // 4: tie rule
      clear_img();
      img[8][8] = 100;
      img[8][9] = 100;
      run_frame(10, 2'b11, 1000, -1);
      img[8][9] = 99;
      run_frame(10, 2'b11, 1000, -1);

      // 5: overflow with consumer stalled
      clear_img();
      img[2][2]   = 100;
      img[3][6]   = 100;
      img[5][10]  = 100;
      img[9][3]   = 100;
      img[11][12] = 100;
      img[13][7]  = 100;
      kp_ready = 1'b0;
      run_frame(10, 2'b01, FD, -1);
      check("kp_held", 32'(kp_valid), 32'd1);
      check("q_pending", 32'(exp_q.size()), 32'(FD));
      kp_ready = 1'b1;
      repeat (8) tick();
      check("kp_drained", 32'(exp_q.size()), 32'd0);
      check("kp_valid_empty", 32'(kp_valid), 32'd0);
      check("drop_hold", 32'(drop_cnt), 32'd2);
      clear_img();
      run_frame(0, 2'b11, 1000, -1);

      // 6: reset mid-frame, then a full frame with an ignored start in RUN
      clear_img();
      img[7][5] = 100;
      threshold = 16'd10;
      mode      = 2'b01;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      send(100, -1);
      rst = 1'b0;
      #1;
      check("midrst_ctrl", 32'({dog_ready, kp_valid, kp_pol, busy, done}), 32'd0);
      check("midrst_coord", 32'({kp_x, kp_y}), 32'd0);
      check("midrst_drop", 32'(drop_cnt), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      run_frame(10, 2'b01, 1000, 50);
      check("kp_latency_2", 32'(kv_rise - acc_cyc[8*W+6]), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
